game_controller: RTL and testbench

GAME_CONTROLLER -- requirements
Module: game_controller

---
 rtl/game_controller_pkg.sv | 61 ++++++
 rtl/game_controller_key_edge.sv | 36 +++
 rtl/game_controller.sv | 93 +++++++++
 tb/tb_game_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_controller_pkg.sv
// Shared game definitions: FSM state codes, synchronizer default, control-word decode.
// Common to the controller and the datapath so both agree on state numbering.
package game_controller_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SEQ    = 3'd2,
        ST_PLAY   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_RESULT = 3'd5
    } state_t;

    localparam int SYNC_STAGES_DEFAULT = 2;

    // Datapath control word; one bit per controller output.
    typedef struct packed {
        logic r1;
        logic r2;
        logic e1;
        logic e2;
        logic e3;
        logic e4;
        logic sel;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // Moore decode: anything not named for a state stays low, codes 6/7 included.
    function automatic ctrl_t decode_ctrl(input logic [2:0] st);
        ctrl_t c;
        c = CTRL_IDLE;
        case (st)
            ST_INIT: begin
                c.r1 = 1'b1;
                c.r2 = 1'b1;
            end
            ST_SETUP: begin
                c.e1 = 1'b1;
                c.r2 = 1'b1;
            end
            ST_SEQ: begin
                c.e3 = 1'b1;
                c.r2 = 1'b1;
            end
            ST_PLAY: begin
                c.e2 = 1'b1;
                c.e4 = 1'b1;
            end
            ST_CHECK: begin
                c.r2 = 1'b1;
            end
            ST_RESULT: begin
                c.sel = 1'b1;
            end
            default: c = CTRL_IDLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/game_controller_key_edge.sv
// Purpose: synchronize the raw active-low enter key and emit one pulse per press.
// Latency: pulse is high SYNC_STAGES+1 cycles after the key falls (registered).
// Backpressure: none; a held key yields a single pulse, release yields nothing.
module key_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic enter_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   key_q;
    logic                   pulse_q;
    logic                   fall;

    // key_q holds the previous synchronized level; a 1->0 step is a press.
    assign fall = key_q & ~sync_q[SYNC_STAGES-1];

    // Reset loads "released" everywhere so leaving reset can never look like a press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '1;
            key_q   <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], key_n};
            key_q   <= sync_q[SYNC_STAGES-1];
            pulse_q <= fall;
        end
    end

    assign enter_pulse = pulse_q;

endmodule

// File: rtl/game_controller.sv
// Purpose: Moore FSM sequencing the memory game datapath (setup, show, play, check, result).
// Latency: outputs decode from the state register, so they follow a transition by one edge.
// Backpressure: none; status inputs are sampled only in the state that owns them.
module game_controller
    import game_controller_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       KEY_ENTER,
    input  logic       end_FPGA,
    input  logic       end_User,
    input  logic       end_time,
    input  logic       win,
    input  logic       match,
    output logic       R1,
    output logic       R2,
    output logic       E1,
    output logic       E2,
    output logic       E3,
    output logic       E4,
    output logic       SEL,
    output logic [2:0] state
);

    logic       enter_pulse;
    logic [2:0] state_q;
    logic [2:0] state_d;
    ctrl_t      ctrl;

    key_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_key_edge (
        .clk        (CLOCK_50),
        .rst_n      (RESET_N),
        .key_n      (KEY_ENTER),
        .enter_pulse(enter_pulse)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Status inputs are already in the CLOCK_50 domain and are used raw.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
                state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (enter_pulse) state_d = ST_SEQ;
            end
            ST_SEQ: begin
                if (end_FPGA) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                // Timeout outranks a completed entry in the same cycle.
                if (end_time)      state_d = ST_RESULT;
                else if (end_User) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (match && !win) state_d = ST_SEQ;
                else               state_d = ST_RESULT;
            end
            ST_RESULT: begin
                if (enter_pulse) state_d = ST_INIT;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_comb begin
        ctrl = decode_ctrl(state_q);
    end

    assign R1    = ctrl.r1;
    assign R2    = ctrl.r2;
    assign E1    = ctrl.e1;
    assign E2    = ctrl.e2;
    assign E3    = ctrl.e3;
    assign E4    = ctrl.e4;
    assign SEL   = ctrl.sel;
    assign state = state_q;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: per-cycle comparison against a behavioural game model
// plus directed scenario checks with hand-derived literal values.
module tb_game_controller;

    localparam int SYNC = 2;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b0;
    logic       KEY_ENTER = 1'b1;
    logic       end_FPGA = 1'b0;
    logic       end_User = 1'b0;
    logic       end_time = 1'b0;
    logic       win      = 1'b0;
    logic       match    = 1'b0;
    logic       R1, R2, E1, E2, E3, E4, SEL;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    int m_state = 0;
    bit model_on = 1'b0;
    bit inject_illegal = 1'b0;
    bit kh [0:SYNC+1];

    always #5 CLOCK_50 = ~CLOCK_50;

    game_controller #(
        .SYNC_STAGES(SYNC)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .KEY_ENTER(KEY_ENTER),
        .end_FPGA (end_FPGA),
        .end_User (end_User),
        .end_time (end_time),
        .win      (win),
        .match    (match),
        .R1       (R1),
        .R2       (R2),
        .E1       (E1),
        .E2       (E2),
        .E3       (E3),
        .E4       (E4),
        .SEL      (SEL),
        .state    (state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected {R1,R2,E1,E2,E3,E4,SEL} for each game phase.
    function automatic logic [6:0] expected_ctrl(input int s);
        case (s)
            0:       return 7'b1100000;  // INIT: clear round and timer
            1:       return 7'b0110000;  // SETUP: load setup, hold timer
            2:       return 7'b0100100;  // SEQ: show sequence, hold timer
            3:       return 7'b0001010;  // PLAY: timer runs, capture user input
            4:       return 7'b0100000;  // CHECK: hold timer
            5:       return 7'b0000001;  // RESULT: result view
            default: return 7'b0000000;
        endcase
    endfunction

    // Game model: a key press counts at the FSM once the sampled key history
    // shows a 1->0 step SYNC+1 samples back.
    always @(posedge CLOCK_50) begin
        bit press;
        int cur;
        press = kh[SYNC+1] && !kh[SYNC];
        cur   = inject_illegal ? 6 : m_state;
        if (!RESET_N) begin
            m_state  = 0;
            model_on = 1'b1;
            for (int i = 0; i <= SYNC+1; i++) kh[i] = 1'b1;
        end else begin
            if (cur == 0)                       m_state = 1;
            else if (cur == 1)                  m_state = press ? 2 : 1;
            else if (cur == 2)                  m_state = end_FPGA ? 3 : 2;
            else if (cur == 3 && end_time)      m_state = 5;
            else if (cur == 3 && end_User)      m_state = 4;
            else if (cur == 3)                  m_state = 3;
            else if (cur == 4)                  m_state = (match && !win) ? 2 : 5;
            else if (cur == 5)                  m_state = press ? 0 : 5;
            else                                m_state = 0;
            for (int i = SYNC+1; i > 0; i--) kh[i] = kh[i-1];
            kh[0] = KEY_ENTER;
        end
    end

    always @(negedge CLOCK_50) begin
        int exp_st;
        if (model_on) begin
            exp_st = inject_illegal ? 6 : m_state;
            chk("cyc_state", state, exp_st);
            chk("cyc_ctrl", {R1, R2, E1, E2, E3, E4, SEL}, expected_ctrl(exp_st));
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic press(input int hold);
        KEY_ENTER = 1'b0;
        repeat (hold) tick();
        KEY_ENTER = 1'b1;
        repeat (4) tick();
    endtask

    task automatic show_seq();
        end_FPGA = 1'b1;
        tick();
        end_FPGA = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;

        // Reset and first enter press
        repeat (3) tick();
        chk("rst_state", state, 0);
        chk("rst_r1r2", {R1, R2}, 2'b11);
        chk("rst_en_sel", {E1, E2, E3, E4, SEL}, 5'b00000);
        RESET_N = 1'b1;
        tick();
        chk("post_rst_setup", state, 1);
        chk("setup_e1", E1, 1);

        KEY_ENTER = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (dut.u_key_edge.enter_pulse) begin
                pulses++;
                chk("pulse_latency", i, SYNC + 1);
            end
            if (i == SYNC + 2) begin
                chk("enter_to_seq", state, 2);
                chk("seq_e3", E3, 1);
            end
        end
        chk("one_pulse_held", pulses, 1);
        KEY_ENTER = 1'b1;
        repeat (5) tick();
        chk("release_no_change", state, 2);

        // Ignored presses, correct round then winning round
        press(6);
        chk("ignore_in_seq", state, 2);
        show_seq();
        chk("play_state", state, 3);
        chk("play_e2e4", {E2, E4}, 2'b11);
        press(6);
        chk("ignore_in_play", state, 3);
        match = 1'b1; win = 1'b0; end_User = 1'b1;
        tick();
        end_User = 1'b0;
        chk("check_state", state, 4);
        chk("check_r2", R2, 1);
        tick();
        chk("next_round_seq", state, 2);
        show_seq();
        win = 1'b1; end_User = 1'b1;
        tick();
        end_User = 1'b0;
        chk("check2_state", state, 4);
        tick();
        chk("win_result", state, 5);
        chk("win_sel", SEL, 1);
        press(6);
        chk("result_to_setup", state, 1);

        // Mismatch round
        press(6);
        show_seq();
        match = 1'b0; win = 1'b0; end_User = 1'b1;
        tick();
        end_User = 1'b0;
        chk("mis_check", state, 4);
        tick();
        chk("mis_result", state, 5);
        chk("mis_sel", SEL, 1);
        KEY_ENTER = 1'b0;
        repeat (SYNC + 2) tick();
        chk("mis_enter_init", state, 0);
        tick();
        chk("mis_then_setup", state, 1);
        KEY_ENTER = 1'b1;
        repeat (4) tick();

        // Timeout and completion in the same cycle
        press(6);
        show_seq();
        match = 1'b1; end_User = 1'b1; end_time = 1'b1;
        tick();
        end_User = 1'b0; end_time = 1'b0;
        chk("simul_result", state, 5);
        press(6);
        match = 1'b0;

        // Reset mid-PLAY
        press(6);
        show_seq();
        chk("pre_rst_e2", E2, 1);
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        chk("midrst_state", state, 0);
        chk("midrst_en", {E1, E2, E3, E4}, 4'b0000);
        chk("midrst_r1r2", {R1, R2}, 2'b11);
        tick();
        chk("midrst_setup", state, 1);

        // Illegal state code recovers through INIT
        force dut.state_q = 3'd6;
        inject_illegal = 1'b1;
        #1;
        chk("forced_code", state, 6);
        release dut.state_q;
        tick();
        inject_illegal = 1'b0;
        chk("illegal_to_init", state, 0);
        tick();
        chk("illegal_then_setup", state, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
